// File: rtl/fft_pkg.sv
// Shared FFT definitions: sequencer FSM states and default frame length.
// Also used by FFTcontroller so both agree on state encoding.
package fft_pkg;

    localparam int unsigned FFT_LEN_DEFAULT = 512;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2
    } state_t;

endpackage

// File: rtl/frame_bank.sv
// Ping-pong sample store: simple dual-port 2*FFT_LEN x DW RAM, addressed {bank, idx}.
// Ports: i_clk, i_rst_n (clears the read register only);
//        write i_we/i_waddr/i_wdata; read i_re/i_raddr -> o_rdata one cycle later.
// o_rdata holds its value when i_re is low, which lets the sink side stall.
module frame_bank #(
    parameter int unsigned FFT_LEN = 512,
    parameter int unsigned DW      = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_we,
    input  logic [$clog2(FFT_LEN):0]        i_waddr,
    input  logic [DW-1:0]                   i_wdata,
    input  logic                            i_re,
    input  logic [$clog2(FFT_LEN):0]        i_raddr,
    output logic [DW-1:0]                   o_rdata
);

    localparam int unsigned DEPTH = 2 * FFT_LEN;

    logic [DW-1:0] mem [DEPTH];

    // Storage array; contents are not reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= mem[i_raddr];
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Collects DSP samples into FFT_LEN-sample frames (two ping-pong banks) and
// streams completed frames to an FFT sink over Avalon-ST with sop/eop.
// Ports: i_clk, i_rst_n; sample input i_enable/i_sample_valid/i_sample;
//        sink i_sink_ready, o_sink_valid/sop/eop/real/imag/inverse;
//        status o_frame_sent (pulse), o_overrun (sticky, i_clr_overrun), o_busy.
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned FFT_LEN = FFT_LEN_DEFAULT,
    parameter int unsigned DW      = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_enable,
    input  logic          i_sample_valid,
    input  logic [DW-1:0] i_sample,
    input  logic          i_sink_ready,
    output logic          o_sink_valid,
    output logic          o_sink_sop,
    output logic          o_sink_eop,
    output logic [DW-1:0] o_sink_real,
    output logic [DW-1:0] o_sink_imag,
    output logic          o_sink_inverse,
    output logic          o_frame_sent,
    output logic          o_overrun,
    input  logic          i_clr_overrun,
    output logic          o_busy
);

    localparam int unsigned   IW       = $clog2(FFT_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(FFT_LEN - 1);

    state_t        state_q, state_d;
    logic [1:0]    full_q, full_d;
    logic          fill_bank_q, fill_bank_d;
    logic          send_bank_q, send_bank_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic          valid_q, valid_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;
    logic          sent_q, sent_d;
    logic          overrun_q, overrun_d;
    logic          busy_q, busy_d;

    logic          other_bank;
    logic          strobe;
    logic          blocked;
    logic          xfer;
    logic          release_bank;
    logic          wr_en;
    logic          rd_en;
    logic [IW-1:0] rd_addr;
    logic [IW-1:0] rd_nxt;

    // Next-state: fill bookkeeping, overrun, and the send FSM.
    always_comb begin
        state_d     = state_q;
        full_d      = full_q;
        fill_bank_d = fill_bank_q;
        send_bank_d = send_bank_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        valid_d     = valid_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        overrun_d   = overrun_q;
        rd_en       = 1'b0;
        rd_addr     = '0;

        other_bank   = ~fill_bank_q;
        strobe       = i_enable && i_sample_valid;
        // Fill bank is only ever full while both banks are full.
        blocked      = full_q[fill_bank_q];
        xfer         = valid_q && i_sink_ready;
        release_bank = xfer && eop_q;
        wr_en        = strobe && !blocked;
        rd_nxt       = rd_idx_q + 1'b1;
        sent_d       = release_bank;

        // Fill side
        if (!i_enable) begin
            wr_idx_d = '0;
        end else if (wr_en) begin
            if (wr_idx_q == LAST_IDX) begin
                wr_idx_d         = '0;
                full_d[fill_bank_q] = 1'b1;
                // Other bank is free if empty or released this very cycle.
                if (!full_q[other_bank] || (release_bank && (send_bank_q == other_bank))) begin
                    fill_bank_d = other_bank;
                end
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end

        if (release_bank) begin
            full_d[send_bank_q] = 1'b0;
            if (blocked) begin
                fill_bank_d = send_bank_q;
            end
        end

        // A strobe arriving on the release cycle is neither written nor
        // flagged: filling only restarts the cycle after the release.
        if (strobe && blocked && !release_bank) begin
            overrun_d = 1'b1;
        end else if (i_clr_overrun) begin
            overrun_d = 1'b0;
        end

        // Send FSM
        case (state_q)
            S_IDLE: begin
                if (|full_q) begin
                    state_d = S_FETCH;
                    // With both full, the non-fill bank completed first.
                    send_bank_d = full_q[other_bank] ? other_bank : fill_bank_q;
                end
            end
            S_FETCH: begin
                rd_en    = 1'b1;
                rd_addr  = '0;
                rd_idx_d = '0;
                state_d  = S_SEND;
                valid_d  = 1'b1;
                sop_d    = 1'b1;
                eop_d    = 1'b0;
            end
            S_SEND: begin
                if (xfer) begin
                    if (eop_q) begin
                        state_d  = S_IDLE;
                        valid_d  = 1'b0;
                        sop_d    = 1'b0;
                        eop_d    = 1'b0;
                        rd_idx_d = '0;
                    end else begin
                        // Prefetch the next word so it is ready with no bubble.
                        rd_en    = 1'b1;
                        rd_addr  = rd_nxt;
                        rd_idx_d = rd_nxt;
                        sop_d    = 1'b0;
                        eop_d    = (rd_nxt == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = |full_d;
    end

    // State registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            full_q      <= '0;
            fill_bank_q <= 1'b0;
            send_bank_q <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            sent_q      <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            fill_bank_q <= fill_bank_d;
            send_bank_q <= send_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            sent_q      <= sent_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    frame_bank #(
        .FFT_LEN (FFT_LEN),
        .DW      (DW)
    ) u_bank (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (wr_en),
        .i_waddr ({fill_bank_q, wr_idx_q}),
        .i_wdata (i_sample),
        .i_re    (rd_en),
        .i_raddr ({send_bank_q, rd_addr}),
        .o_rdata (o_sink_real)
    );

    assign o_sink_valid   = valid_q;
    assign o_sink_sop     = sop_q;
    assign o_sink_eop     = eop_q;
    assign o_sink_imag    = '0;
    assign o_sink_inverse = 1'b0;
    assign o_frame_sent   = sent_q;
    assign o_overrun      = overrun_q;
    assign o_busy         = busy_q;

endmodule
